// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: issue/result bundle between the E-stage and the multiply/divide unit.
interface mult_div_unit_if;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    modport master (output Start, Op, A, B, input Busy, HI, LO);
    modport slave  (input Start, Op, A, B, output Busy, HI, LO);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: MIPS-style HI/LO multiply/divide unit with fixed 5/10-cycle latency.
// Define MDU_MADD_EN to enable madd/msub; otherwise Op 110/111 are no-ops.
module mult_div_unit (
    input logic            Clk,
    input logic            Reset,
    mult_div_unit_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    localparam logic [2:0] OP_MULTU = 3'b001, OP_MTHI = 3'b100, OP_MTLO = 3'b101;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic        start_mul, start_div, div_q, msgn, dsgn;
    logic [63:0] ae, be, prod, mres;
    logic [31:0] ua, ub, uq, ur, qd, rd;
`ifdef MDU_MADD_EN
    assign start_mul = bus.Op[2:1] == 2'b00 || bus.Op[2:1] == 2'b11;
`else
    assign start_mul = bus.Op[2:1] == 2'b00;
`endif
    assign start_div = bus.Op[2:1] == 2'b01;
    assign div_q     = op_q[2:1] == 2'b01;
    // A 64x64 product truncated to 64 bits is correct for both signednesses once extended.
    assign msgn = op_q != OP_MULTU;
    assign ae   = {{32{msgn & a_q[31]}}, a_q};
    assign be   = {{32{msgn & b_q[31]}}, b_q};
    assign prod = ae * be;
`ifdef MDU_MADD_EN
    assign mres = op_q[2] ? (op_q[0] ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod) : prod;
`else
    assign mres = prod;
`endif
    // Signed divide on magnitudes; 0x80000000 / -1 falls out as 0x80000000 with remainder 0.
    assign dsgn = ~op_q[0];
    assign ua   = (dsgn && a_q[31]) ? -a_q : a_q;
    assign ub   = (dsgn && b_q[31]) ? -b_q : b_q;
    assign uq   = ub == '0 ? '0 : ua / ub;
    assign ur   = ub == '0 ? '0 : ua % ub;
    assign qd   = (dsgn && (a_q[31] ^ b_q[31])) ? -uq : uq;
    assign rd   = (dsgn && a_q[31]) ? -ur : ur;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (state_q == IDLE) begin
            if (bus.Start) begin
                hi_d = bus.Op == OP_MTHI ? bus.A : hi_q;
                lo_d = bus.Op == OP_MTLO ? bus.A : lo_q;
                if (start_mul || start_div) begin
                    state_d = BUSY;
                    cnt_d   = start_div ? 4'd10 : 4'd5;
                    op_d    = bus.Op;
                    a_d     = bus.A;
                    b_d     = bus.B;
                end
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                if (!div_q) {hi_d, lo_d} = mres;
                else if (b_q != '0) {hi_d, lo_d} = {rd, qd};
            end
        end
    end
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign bus.Busy = state_q == BUSY;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule
